// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the LSU (req 0) and a debug/DMA loader (req 1).
// Optional macro DMEM_ARB_MISALIGN_EN: misaligned halfword/word accesses get an error response instead of a strobe.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    input  logic [5:0]              req_funct3,
    output logic [1:0]              rsp_valid,
    output logic                    rsp_err,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    mem_read_en,
    output logic                    mem_write_en,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_data_in,
    output logic [2:0]              mem_funct3,
    input  logic [DATA_WIDTH-1:0]   mem_data_out
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q;
    logic                    we_q;
    logic                    legal_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [2:0]              funct3_q;
    logic [1:0]              rsp_valid_q;
    logic                    rsp_err_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;

    logic                    grant_d;
    logic                    accept;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [2:0]              sel_funct3;
    logic                    funct3_ok;
    logic                    misaligned;
    logic                    sel_legal;

    // Contention goes to whoever did not win last time.
    always_comb begin
        grant_d = 1'b0;
        case (req_valid)
            2'b01:   grant_d = 1'b0;
            2'b10:   grant_d = 1'b1;
            2'b11:   grant_d = ~last_grant_q;
            default: grant_d = 1'b0;
        endcase
    end

    assign accept     = (state_q == IDLE) && (|req_valid);
    assign sel_we     = grant_d ? req_we[1] : req_we[0];
    assign sel_addr   = grant_d ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
    assign sel_wdata  = grant_d ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];
    assign sel_funct3 = grant_d ? req_funct3[5:3] : req_funct3[2:0];

    always_comb begin
        funct3_ok = 1'b0;
        case (sel_funct3)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b100, 3'b101:         funct3_ok = ~sel_we;
            default:                funct3_ok = 1'b0;
        endcase
    end

`ifdef DMEM_ARB_MISALIGN_EN
    assign misaligned = (((sel_funct3 == 3'b001) || (sel_funct3 == 3'b101)) && sel_addr[0])
                      || ((sel_funct3 == 3'b010) && (sel_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign sel_legal = funct3_ok && !misaligned;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes depend only on the state register so reset kills them at once.
    always_comb begin
        req_ready    = 2'b00;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        case (state_q)
            IDLE:    if (accept) req_ready = grant_d ? 2'b10 : 2'b01;
            ACCESS: begin
                mem_read_en  = legal_q & ~we_q;
                mem_write_en = legal_q & we_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            legal_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            if (accept) begin
                last_grant_q <= grant_d;
                we_q         <= sel_we;
                legal_q      <= sel_legal;
                addr_q       <= sel_addr;
                wdata_q      <= sel_wdata;
                funct3_q     <= sel_funct3;
            end
            if (state_q == ACCESS) begin
                rsp_valid_q <= last_grant_q ? 2'b10 : 2'b01;
                rsp_err_q   <= ~legal_q;
                rsp_rdata_q <= (legal_q && !we_q) ? mem_data_out : '0;
            end
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign mem_address = addr_q;
    assign mem_data_in = wdata_q;
    assign mem_funct3  = funct3_q;

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: requester 0 (core load/store unit) and requester 1 (debug/DMA loader).
- Arbitrates round-robin, latches the granted request, and drives the memory strobes, address, write data and funct3 for exactly one cycle.
- Returns a registered response (read data or write acknowledge) to the granted requester.
- Sits between the LSU/debug logic and the data memory. Filters illegal access types before they reach memory.

Parameters:
- ADDR_WIDTH, 32, width of each request address and mem_address.
- DATA_WIDTH, 32, width of write/read data.

Ports:
- clock  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  2  request valid; bit i = requester i.
- req_ready  output  2  request accepted this cycle; at most one bit high.
- req_we  input  2  1 = store, 0 = load.
- req_addr  input  2*ADDR_WIDTH  byte address; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  2*DATA_WIDTH  store data, same slicing.
- req_funct3  input  6  access type (insn[14:12] encoding); slice i = [i*3 +: 3].
- rsp_valid  output  2  one-cycle response pulse to requester i.
- rsp_err  output  1  response is an error; qualified by rsp_valid.
- rsp_rdata  output  DATA_WIDTH  load data; 0 for stores and errors.
- mem_read_en  output  1  memory read strobe.
- mem_write_en  output  1  memory write strobe.
- mem_address  output  ADDR_WIDTH  memory address.
- mem_data_in  output  DATA_WIDTH  memory write data.
- mem_funct3  output  3  memory access type.
- mem_data_out  input  DATA_WIDTH  combinational memory read data.

Behaviour:
- Reset (async) values: state=IDLE, last_grant=1, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_read_en=0, mem_write_en=0, mem_address=0, mem_data_in=0, mem_funct3=0.
- States: IDLE, ACCESS.
- IDLE:
  - req_ready is combinational. If exactly one req_valid bit is set, grant it. If both are set, grant the requester that is not last_grant.
  - On the grant edge: latch we/addr/wdata/funct3 and the grant index, update last_grant, go to ACCESS.
  - If no request is valid, stay in IDLE.
- ACCESS:
  - req_ready=0.
  - Legal request: drive mem_read_en=!we, mem_write_en=we, with address/data/funct3 from the latched registers, for exactly this one cycle.
  - On the next edge: rsp_rdata<=mem_data_out for loads, 0 for stores; rsp_valid[grant]<=1; go to IDLE.
- Latency:
  - Accept in cycle N, memory strobe in N+1, rsp_valid in N+2.
  - Maximum throughput is one accept per 2 cycles. The next accept may coincide with the previous response cycle.
- rsp_valid is a single-cycle pulse with no back-pressure; requesters must sample it.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
- Illegal funct3: no memory strobe in ACCESS; response carries rsp_err=1 and rsp_rdata=0. last_grant updates normally.
- mem_address, mem_data_in and mem_funct3 hold the last latched values outside ACCESS. Strobes are 0 outside ACCESS.
- Fairness: with both requesters valid continuously, grants strictly alternate, so neither waits more than one transaction.
- A requester must hold valid and request fields stable until req_ready. Dropping valid before grant withdraws the request without side effects.
- Reset asserted in ACCESS: strobes drop immediately; no response is issued; the transaction is lost.
- Address arithmetic: none. The full byte address is passed through; memory performs word indexing.

Optional Feature:
- Macro: DMEM_ARB_MISALIGN_EN.
- Defined: a misaligned access is treated like an illegal funct3 (no strobe, rsp_err=1, rsp_rdata=0). Misaligned means:
  - halfword (funct3 001/101) with addr[0]=1;
  - word (010) with addr[1:0]!=0.
- Undefined: alignment is not checked; the address is forwarded unchanged.

Test Plan:
- Req0 load, funct3=010, addr=0x10; mem_data_out=0xDEADBEEF -> mem_read_en high for 1 cycle at N+1; rsp_valid=01, rsp_rdata=0xDEADBEEF, rsp_err=0 at N+2.
- Both requesters valid continuously for 4 transactions after reset -> grant order 0,1,0,1; req_ready never 11.
- Req1 store, funct3=000, addr=0x8, wdata=0x000000A5 -> mem_write_en=1, mem_address=0x8, mem_data_in=0xA5, mem_funct3=000 for 1 cycle; rsp_valid=10, rsp_rdata=0.
- Req0 load, funct3=011 -> no mem strobe; rsp_valid=01, rsp_err=1, rsp_rdata=0.
- Assert reset during ACCESS of a store -> mem_write_en falls in the same cycle; no rsp_valid; after release, state=IDLE and req0 wins the next contention.
- With DMEM_ARB_MISALIGN_EN, load funct3=010, addr=0x6 -> error response, no strobe. Without the macro: normal read of addr 0x6.
